// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct codes, FSM states and default width for the EX-stage multiplier
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MULT  = 6'd24;
  localparam logic [5:0] MFHI  = 6'd16;
  localparam logic [5:0] MFLO  = 6'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - shift-add multiply datapath: product register, carry-keeping adder, right shift
module mul_shift_add_dp
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;

  // The extra sum bit carries into the MSB as the whole product shifts right.
  always_comb begin
    sum = {1'b0, product_q[2*WIDTH-1:WIDTH]};
    if (product_q[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    product_d = product_q;
    if (load_i) begin
      product_d = {{WIDTH{1'b0}}, mplier_i};
    end else if (step_i) begin
      product_d = {sum, product_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/multu_sequencer.sv
// rtl/multu_sequencer.sv - MULTU sequencer: 32-step shift-add, HI/LO commit, MFHI/MFLO read and stall
// Optional MULT_SIGNED_EN: also accepts MULT via magnitude multiply and conditional negation.
module multu_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             mfhi_req_i,
  input  logic             mflo_req_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               is_mul, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product, result;

`ifdef MULT_SIGNED_EN
  logic neg_q;
  logic is_signed;

  assign is_mul    = (funct_i == MULTU) || (funct_i == MULT);
  assign is_signed = (funct_i == MULT);
  assign mag_a     = (is_signed && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
  assign mag_b     = (is_signed && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
  assign result    = neg_q ? -product : product;
`else
  assign is_mul    = (funct_i == MULTU);
  assign mag_a     = op_a_i;
  assign mag_b     = op_b_i;
  assign result    = product;
`endif

  assign accept = (state_q == IDLE) && issue_valid_i && is_mul;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .step_i    (state_q == RUN),
    .mcand_i   (mcand_q),
    .mplier_i  (mag_b),
    .product_o (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q <= mag_a;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef MULT_SIGNED_EN
            neg_q   <= is_signed && (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
`endif
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          hi_q    <= result[2*WIDTH-1:WIDTH];
          lo_q    <= result[WIDTH-1:0];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A read in the accepting cycle is older than the multiply, so it sees the old HI/LO.
  assign busy_o    = (state_q != IDLE);
  assign stall_o   = busy_o && (issue_valid_i || mfhi_req_i || mflo_req_i);
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign rd_data_o = mfhi_req_i ? hi_q : lo_q;

endmodule

// File: tb/tb_multu_sequencer.sv
// tb/tb_multu_sequencer.sv - directed self-checking bench for multu_sequencer
module tb_multu_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        mfhi_req = 1'b0, mflo_req = 1'b0;
  logic [31:0] rd_data, hi, lo;
  logic        busy, stall, done;

  int n_chk = 0;
  int n_fail = 0;

  multu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid_i(issue_valid),
    .funct_i      (funct),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .mfhi_req_i   (mfhi_req),
    .mflo_req_i   (mflo_req),
    .rd_data_o    (rd_data),
    .hi_o         (hi),
    .lo_o         (lo),
    .busy_o       (busy),
    .stall_o      (stall),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(mfhi_req && mflo_req)) else begin
        n_fail++;
        $error("FAIL protocol: mfhi_req and mflo_req both high");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    funct = f;
    op_a = a;
    op_b = b;
    #1;
    chk("issue_stall", stall, 0);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, n, lat);
    tick();
  endtask

  initial begin
    tick();
    tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    tick();

    // 3*5 with MFLO arriving at cycle 5
    issue(MULTU, 32'd3, 32'd5);
    repeat (4) tick();
    mflo_req = 1'b1;
    for (int c = 5; c <= 33; c++) begin
      #1;
      chk($sformatf("t1_stall_c%0d", c), stall, 1);
      chk($sformatf("t1_done_c%0d", c), done, (c == 33) ? 1 : 0);
      tick();
    end
    #1;
    chk("t1_stall_34", stall, 0);
    chk("t1_rd_data", rd_data, 32'd15);
    chk("t1_hi", hi, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done_34", done, 0);
    mflo_req = 1'b0;
    tick();

    // carry path
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("t2", 32);
    #1;
    chk("t2_hi", hi, 32'hFFFF_FFFE);
    chk("t2_lo", lo, 32'h0000_0001);

    // issue while busy is dropped
    tick();
    issue(MULTU, 32'h10, 32'h20);
    repeat (9) tick();
    issue_valid = 1'b1;
    funct = MULTU;
    op_a = 32'd7;
    op_b = 32'd9;
    for (int c = 10; c <= 12; c++) begin
      #1;
      chk($sformatf("t3_stall_c%0d", c), stall, 1);
      tick();
    end
    issue_valid = 1'b0;
    wait_done("t3", 20);
    #1;
    chk("t3_hi", hi, 0);
    chk("t3_lo", lo, 32'h200);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_not_queued", busy, 0);

    // reset mid-run
    issue(MULTU, 32'h1234, 32'h10);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_hi", hi, 0);
    chk("t4_lo", lo, 0);
    chk("t4_done", done, 0);
    for (int c = 0; c < 25; c++) begin
      tick();
      chk($sformatf("t4_no_done_%0d", c), done, 0);
    end
    issue(MULTU, 32'd2, 32'd2);
    wait_done("t4b", 32);
    #1;
    chk("t4b_lo", lo, 32'd4);
    chk("t4b_hi", hi, 0);

    // old HI read alongside an accepted issue
    tick();
    issue(MULTU, 32'h1234_0000, 32'h0001_0000);
    wait_done("t5a", 32);
    #1;
    chk("t5a_hi", hi, 32'h1234);
    chk("t5a_lo", lo, 0);
    tick();
    mfhi_req = 1'b1;
    issue_valid = 1'b1;
    funct = MULTU;
    op_a = 32'h8000_0000;
    op_b = 32'd2;
    #1;
    chk("t5_stall", stall, 0);
    chk("t5_rd_old_hi", rd_data, 32'h1234);
    tick();
    issue_valid = 1'b0;
    mfhi_req = 1'b0;
    wait_done("t5", 32);
    #1;
    chk("t5_hi", hi, 32'd1);
    chk("t5_lo", lo, 0);

    // non-multiply funct ignored
    tick();
    issue(MFHI, 32'd5, 32'd5);
    #1;
    chk("t6_mfhi_funct_busy", busy, 0);

    // MULT -2 * 3
    tick();
`ifdef MULT_SIGNED_EN
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done("t7", 32);
    #1;
    chk("t7_hi", hi, 32'hFFFF_FFFF);
    chk("t7_lo", lo, 32'hFFFF_FFFA);
`else
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    chk("t7_busy", busy, 0);
    tick();
    chk("t7_busy_later", busy, 0);
    chk("t7_hi", hi, 32'd1);
    chk("t7_lo", lo, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
